// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// word geometry and the fault classification used on request accept.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam int DMEM_WORD_BYTES = 4;
    localparam int WORD_SHIFT      = $clog2(DMEM_WORD_BYTES);

    typedef enum logic [1:0] {
        FAULT_NONE,
        MISALIGN,
        RANGE,
        CONFLICT
    } fault_cause_e;

    // A simultaneous load+store outranks address problems so it is never
    // mistaken for a plain misaligned or out-of-range access.
    function automatic fault_cause_e classify_fault(
        input logic [31:0] addr,
        input logic        rd,
        input logic        wr,
        input int unsigned depth_words
    );
        logic [31:0] word_idx;
        word_idx = addr >> WORD_SHIFT;
        if (rd && wr) begin
            return CONFLICT;
        end else if (addr[WORD_SHIFT-1:0] != '0) begin
            return MISALIGN;
        end else if (word_idx >= depth_words) begin
            return RANGE;
        end
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory bus between the memory-access stage (master) and the
// responder (slave); requests are combinational, the response is registered.
interface dmem_if;

    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_read_en;
    logic        dmem_write_en;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        dmem_fault;

    modport master (
        output dmem_addr,
        output dmem_wdata,
        output dmem_read_en,
        output dmem_write_en,
        input  dmem_rdata,
        input  dmem_ready,
        input  dmem_fault
    );

    modport slave (
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_read_en,
        input  dmem_write_en,
        output dmem_rdata,
        output dmem_ready,
        output dmem_fault
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Single-port DEPTH_WORDS x 32 backing store with a registered read port;
// contents survive reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic                           re_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // NOTE: the array and its read register carry no reset, so the tools can
    // map them onto a RAM macro; the responder masks rdata outside a response.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: accepts one word access at a time, waits WAIT_STATES
// cycles, then presents a one-cycle response with ready, data and fault.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic clk,
    input  logic reset,
    dmem_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] WS_INIT = CW'(WAIT_STATES);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("dmem_responder: WAIT_STATES must be within 0..15");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS must be a power of two >= 2");
    end

    state_e       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] word_q;
    logic [31:0]  wdata_q;
    logic         load_q;
    logic         store_q;
    fault_cause_e cause_q;

    logic         req;
    logic         accept;
    fault_cause_e accept_cause;

    // Operation presented to the array: live inputs during the accept cycle
    // (needed when WAIT_STATES==0), the latched copy afterwards.
    logic [AW-1:0] op_word;
    logic [31:0]   op_wdata;
    logic          op_load;
    logic          op_store;
    logic          op_fault;
    logic          mem_we;
    logic          mem_re;
    logic [31:0]   arr_rdata;

    assign req          = bus.dmem_read_en | bus.dmem_write_en;
    assign accept       = (state_q == IDLE) && req;
    assign accept_cause = classify_fault(bus.dmem_addr, bus.dmem_read_en,
                                         bus.dmem_write_en, DEPTH_WORDS);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q  <= '0;
            wdata_q <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            cause_q <= FAULT_NONE;
        end else if (accept) begin
            word_q  <= bus.dmem_addr[AW+WORD_SHIFT-1:WORD_SHIFT];
            wdata_q <= bus.dmem_wdata;
            load_q  <= bus.dmem_read_en;
            store_q <= bus.dmem_write_en;
            cause_q <= accept_cause;
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default at
    // the top, so no path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d   = WS_INIT;
                    state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (state_q == IDLE) begin
            op_word  = bus.dmem_addr[AW+WORD_SHIFT-1:WORD_SHIFT];
            op_wdata = bus.dmem_wdata;
            op_load  = bus.dmem_read_en;
            op_store = bus.dmem_write_en;
            op_fault = (accept_cause != FAULT_NONE);
        end else begin
            op_word  = word_q;
            op_wdata = wdata_q;
            op_load  = load_q;
            op_store = store_q;
            op_fault = (cause_q != FAULT_NONE);
        end

        // The array is only touched on the edge that enters RESP, so an
        // abandoned (reset) access can never commit its store.
        mem_we = (state_d == RESP) && (state_q != RESP) && op_store && !op_fault;
        mem_re = (state_d == RESP) && (state_q != RESP) && op_load  && !op_fault;

        bus.dmem_ready = ((state_q == IDLE) && !req) || (state_q == RESP);
        bus.dmem_fault = (state_q == RESP) && (cause_q != FAULT_NONE);
        bus.dmem_rdata = '0;
        if ((state_q == RESP) && load_q && (cause_q == FAULT_NONE)) begin
            bus.dmem_rdata = arr_rdata;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .we_i   (mem_we),
        .re_i   (mem_re),
        .addr_i (op_word),
        .wdata_i(op_wdata),
        .rdata_o(arr_rdata)
    );

    fault_only_in_resp: assert property (
        @(posedge clk) disable iff (!reset) bus.dmem_fault |-> (state_q == RESP)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (WAIT_STATES 1, 0, 3)
// driven through a shared stimulus bus selected by 'sel'.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic [2:0]  rst_n;
    int          sel;
    logic        re, we;
    logic [31:0] addr, wdata;
    logic        ready, fault;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_if if0 ();
    dmem_if if1 ();
    dmem_if if2 ();

    assign if0.dmem_addr     = addr;
    assign if0.dmem_wdata    = wdata;
    assign if0.dmem_read_en  = re && (sel == 0);
    assign if0.dmem_write_en = we && (sel == 0);
    assign if1.dmem_addr     = addr;
    assign if1.dmem_wdata    = wdata;
    assign if1.dmem_read_en  = re && (sel == 1);
    assign if1.dmem_write_en = we && (sel == 1);
    assign if2.dmem_addr     = addr;
    assign if2.dmem_wdata    = wdata;
    assign if2.dmem_read_en  = re && (sel == 2);
    assign if2.dmem_write_en = we && (sel == 2);

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(rst_n[0]), .bus(if0));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst_n[1]), .bus(if1));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(rst_n[2]), .bus(if2));

    always_comb begin
        case (sel)
            0:       begin ready = if0.dmem_ready; fault = if0.dmem_fault; rdata = if0.dmem_rdata; end
            1:       begin ready = if1.dmem_ready; fault = if1.dmem_fault; rdata = if1.dmem_rdata; end
            default: begin ready = if2.dmem_ready; fault = if2.dmem_fault; rdata = if2.dmem_rdata; end
        endcase
    end

    typedef struct {
        int          sel;
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_low;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input int s, input logic r, input logic w,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] er, input logic ef, input int el);
        vec_t v;
        v.sel = s; v.re = r; v.we = w; v.addr = a; v.wdata = d;
        v.exp_rdata = er; v.exp_fault = ef; v.exp_low = el;
        vecs.push_back(v);
    endfunction

    // Samples at negedge+1 each cycle until ready; counts not-ready cycles and
    // notes any fault/rdata activity outside the response cycle.
    task automatic wait_resp(output int low, output bit done, output bit quiet);
        low = 0; done = 1'b0; quiet = 1'b1;
        for (int c = 0; c < 32 && !done; c++) begin
            #1;
            if (ready === 1'b1) begin
                done = 1'b1;
            end else begin
                low++;
                if (fault !== 1'b0 || rdata !== 32'h0) quiet = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic run_access(input string tag, input vec_t v);
        int low; bit done; bit quiet;
        @(negedge clk);
        sel = v.sel; re = v.re; we = v.we; addr = v.addr; wdata = v.wdata;
        wait_resp(low, done, quiet);
        check({tag, " responded"}, 32'(done), 32'd1);
        if (done) begin
            check({tag, " rdata"}, rdata, v.exp_rdata);
            check({tag, " fault"}, 32'(fault), 32'(v.exp_fault));
            check({tag, " ready-low cycles"}, 32'(low), 32'(v.exp_low));
            check({tag, " quiet before resp"}, 32'(quiet), 32'd1);
        end
        re = 1'b0; we = 1'b0;
    endtask

    initial begin
        int low; bit done; bit quiet;
        vec_t v;

        rst_n = 3'b000; sel = 0; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;

        // WAIT_STATES=1: two not-ready cycles per access.
        add(0, 0, 1, 32'h10,        32'hDEADBEEF, 32'h0,        0, 2);
        add(0, 1, 0, 32'h10,        32'h0,        32'hDEADBEEF, 0, 2);
        add(0, 0, 1, 32'h0,         32'h12345678, 32'h0,        0, 2);
        add(0, 1, 0, 32'h12,        32'h0,        32'h0,        1, 2);
        add(0, 0, 1, 32'h1000,      32'h55,       32'h0,        1, 2);
        add(0, 1, 0, 32'h0,         32'h0,        32'h12345678, 0, 2);
        add(0, 0, 1, 32'h20,        32'h11,       32'h0,        0, 2);
        add(0, 1, 1, 32'h20,        32'hFF,       32'h0,        1, 2);
        add(0, 1, 0, 32'h20,        32'h0,        32'h11,       0, 2);
        add(0, 0, 1, 32'hFFC,       32'hCAFEF00D, 32'h0,        0, 2);
        add(0, 1, 0, 32'hFFC,       32'h0,        32'hCAFEF00D, 0, 2);
        add(0, 1, 0, 32'hFFFFFFFC,  32'h0,        32'h0,        1, 2);
        // WAIT_STATES=0: back-to-back, one not-ready cycle each.
        add(1, 0, 1, 32'h0,         32'd1,        32'h0,        0, 1);
        add(1, 0, 1, 32'h4,         32'd2,        32'h0,        0, 1);
        add(1, 0, 1, 32'h8,         32'd3,        32'h0,        0, 1);
        add(1, 1, 0, 32'h0,         32'h0,        32'd1,        0, 1);
        add(1, 1, 0, 32'h4,         32'h0,        32'd2,        0, 1);
        add(1, 1, 0, 32'h8,         32'h0,        32'd3,        0, 1);
        // WAIT_STATES=3: four not-ready cycles per access.
        add(2, 0, 1, 32'h40,        32'h0BADF00D, 32'h0,        0, 4);
        add(2, 0, 1, 32'h44,        32'h44444444, 32'h0,        0, 4);
        add(2, 1, 0, 32'h40,        32'h0,        32'h0BADF00D, 0, 4);

        // Reset state of every instance.
        #3;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check($sformatf("reset ready dut%0d", s), 32'(ready), 32'd1);
            check($sformatf("reset rdata dut%0d", s), rdata, 32'h0);
            check($sformatf("reset fault dut%0d", s), 32'(fault), 32'd0);
        end
        @(negedge clk); rst_n = 3'b111;

        foreach (vecs[i]) run_access($sformatf("vec%0d", i), vecs[i]);

        // Reset during WAIT abandons the store to 0x40.
        @(negedge clk);
        sel = 2; re = 1'b0; we = 1'b1; addr = 32'h40; wdata = 32'hAAAA5555;
        @(negedge clk); @(negedge clk); #1;
        check("pre-reset ready in WAIT", 32'(ready), 32'd0);
        rst_n[2] = 1'b0; we = 1'b0; #1;
        check("mid-reset ready", 32'(ready), 32'd1);
        check("mid-reset rdata", rdata, 32'h0);
        check("mid-reset fault", 32'(fault), 32'd0);
        @(negedge clk); rst_n[2] = 1'b1; #1;
        check("post-reset idle ready", 32'(ready), 32'd1);
        v = '{sel: 2, re: 1'b1, we: 1'b0, addr: 32'h40, wdata: 32'h0,
              exp_rdata: 32'h0BADF00D, exp_fault: 1'b0, exp_low: 4};
        run_access("load after aborted store", v);

        // Address changes mid-WAIT: response still uses the accepted address.
        @(negedge clk);
        sel = 2; re = 1'b1; we = 1'b0; addr = 32'h40;
        #1 check("midwait accept ready", 32'(ready), 32'd0);
        @(negedge clk); @(negedge clk);
        addr = 32'h44;
        wait_resp(low, done, quiet);
        check("midwait responded", 32'(done), 32'd1);
        check("midwait rdata", rdata, 32'h0BADF00D);
        check("midwait ready-low cycles", 32'(low), 32'd2);
        re = 1'b0;
        @(negedge clk); #1;
        check("midwait back to idle", 32'(ready), 32'd1);
        @(negedge clk); #1;
        check("midwait no second access", 32'(ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
